// File: rtl/e1_clk_servo_pkg.sv
// ============================================================================
// e1_clk_servo_pkg : shared widths, FSM encoding and saturation limits
// Revision: 1.0
// ============================================================================
`default_nettype none

package e1_clk_servo_pkg;

  localparam int c_tune_width = 12;
  localparam int c_cnt_width  = 16;
  localparam int c_int_width  = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIFF  = 3'd1,
    ST_INTEG = 3'd2,
    ST_SUM   = 3'd3,
    ST_CLAMP = 3'd4
  } servo_state_t;

  // Symmetric limits keep the integrator away from the unbalanced most-negative code
  localparam logic signed [c_int_width-1:0] c_int_sat_max = {1'b0, {(c_int_width-1){1'b1}}};
  localparam logic signed [c_int_width-1:0] c_int_sat_min = {1'b1, {(c_int_width-2){1'b0}}, 1'b1};

endpackage

`default_nettype wire

// File: rtl/servo_sat_acc.sv
// ============================================================================
// servo_sat_acc : signed accumulator saturating at +/-(2^(WIDTH-1)-1), with clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module servo_sat_acc
  import e1_clk_servo_pkg::*;
#(
  parameter int WIDTH = c_int_width
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_din,
  output logic signed [WIDTH-1:0] o_acc
);

  localparam logic signed [WIDTH:0] c_max = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] c_min = {2'b11, {(WIDTH-2){1'b0}}, 1'b1};

  logic signed [WIDTH:0]   w_sum;
  logic signed [WIDTH-1:0] w_next;

  // One guard bit is enough: both operands already lie inside the limits
  assign w_sum = {o_acc[WIDTH-1], o_acc} + {i_din[WIDTH-1], i_din};

  always_comb begin
    w_next = w_sum[WIDTH-1:0];
    if (w_sum > c_max)
      w_next = c_max[WIDTH-1:0];
    else if (w_sum < c_min)
      w_next = c_min[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_acc <= '0;
    else if (i_clr)
      o_acc <= '0;
    else if (i_en)
      o_acc <= w_next;
  end

endmodule

`default_nettype wire

// File: rtl/e1_clk_servo.sv
// ============================================================================
// e1_clk_servo : E1-tick vs USB-SOF frequency-lock loop driving the clock tune PDM
// Revision: 1.0
// ============================================================================
`default_nettype none

module e1_clk_servo
  import e1_clk_servo_pkg::*;
#(
  parameter int TUNE_WIDTH = c_tune_width,
  parameter int CNT_WIDTH  = c_cnt_width,
  parameter int INT_WIDTH  = c_int_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_e1_rx,
  input  logic                  tick_usb_sof,
  input  logic                  cfg_en,
  input  logic [CNT_WIDTH-1:0]  cfg_nominal,
  input  logic [TUNE_WIDTH-1:0] cfg_center,
  input  logic [3:0]            cfg_kp_shift,
  input  logic [3:0]            cfg_ki_shift,
  input  logic                  stat_clr,
  output logic [TUNE_WIDTH-1:0] tune_val,
  output logic                  tune_oe,
  output logic                  tune_stb,
  output logic [CNT_WIDTH-1:0]  stat_err,
  output logic                  stat_overrun
);

  localparam int c_sum_w = TUNE_WIDTH + INT_WIDTH + 2;
  localparam logic signed [c_sum_w-1:0] c_tune_max =
    {{(c_sum_w-TUNE_WIDTH){1'b0}}, {TUNE_WIDTH{1'b1}}};

  servo_state_t r_state, w_state_nxt;

  logic [CNT_WIDTH-1:0]         r_cnt, r_cap, r_prev;
  logic [CNT_WIDTH-1:0]         w_cnt_nxt, w_delta, w_err_new;
  logic                         r_primed;
  logic signed [CNT_WIDTH-1:0]  r_err;
  logic signed [INT_WIDTH-1:0]  w_err_ext, w_integ, w_integ_sh;
  logic signed [c_sum_w-1:0]    w_center_ext, w_err_sum, w_p_term, w_i_term, w_sum, r_sum;
  logic [TUNE_WIDTH-1:0]        w_clamped;
  logic                         w_busy, w_start, w_acc_en, w_stb, w_acc_clr;

  // A tick coinciding with SOF is already folded into the captured value
  assign w_cnt_nxt = r_cnt + {{(CNT_WIDTH-1){1'b0}}, tick_e1_rx};
  assign w_delta   = r_cap - r_prev;
  assign w_err_new = w_delta - cfg_nominal;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_start   = tick_usb_sof & cfg_en & r_primed & ~w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_cap  <= '0;
      r_prev <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (tick_usb_sof) begin
        r_prev <= r_cap;
        r_cap  <= w_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_en    = 1'b0;
    w_stb       = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_DIFF;
      ST_DIFF:  w_state_nxt = ST_INTEG;
      ST_INTEG: begin
        w_acc_en    = 1'b1;
        w_state_nxt = ST_SUM;
      end
      ST_SUM:   w_state_nxt = ST_CLAMP;
      ST_CLAMP: begin
        w_stb       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
    // Disabling aborts any pass in flight without a strobe
    if (!cfg_en) begin
      w_state_nxt = ST_IDLE;
      w_acc_en    = 1'b0;
      w_stb       = 1'b0;
    end
  end

  assign tune_stb  = w_stb;
  assign w_acc_clr = ~cfg_en;
  assign w_err_ext = INT_WIDTH'(r_err);

  servo_sat_acc #(
    .WIDTH (INT_WIDTH)
  ) u_integ (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_acc_clr),
    .i_en  (w_acc_en),
    .i_din (w_err_ext),
    .o_acc (w_integ)
  );

  // Every term is widened before adding, so the sum never wraps
  assign w_integ_sh   = w_integ >>> cfg_ki_shift;
  assign w_center_ext = $signed({{(c_sum_w-TUNE_WIDTH){1'b0}}, cfg_center});
  assign w_err_sum    = c_sum_w'(r_err);
  assign w_p_term     = w_err_sum <<< cfg_kp_shift;
  assign w_i_term     = c_sum_w'(w_integ_sh);
  assign w_sum        = w_center_ext + w_p_term + w_i_term;

  always_comb begin
    w_clamped = r_sum[TUNE_WIDTH-1:0];
    if (r_sum[c_sum_w-1])
      w_clamped = '0;
    else if (r_sum > c_tune_max)
      w_clamped = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_primed <= 1'b0;
      r_err    <= '0;
      r_sum    <= '0;
      tune_val <= '0;
      tune_oe  <= 1'b0;
      stat_err <= '0;
    end else begin
      tune_oe <= cfg_en;
      if (!cfg_en) begin
        r_primed <= 1'b0;
        tune_val <= cfg_center;
      end else begin
        if (tick_usb_sof && !r_primed)
          r_primed <= 1'b1;
        if (r_state == ST_DIFF) begin
          r_err    <= w_err_new;
          stat_err <= w_err_new;
        end
        if (r_state == ST_SUM)
          r_sum <= w_sum;
        if (w_stb)
          tune_val <= w_clamped;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stat_overrun <= 1'b0;
    else if (tick_usb_sof && w_busy)
      stat_overrun <= 1'b1;
    else if (stat_clr)
      stat_overrun <= 1'b0;
  end

endmodule

`default_nettype wire
